// File: rtl/bus_mux_encoded.sv
// Registered shared-bus multiplexer driven by one-hot source strobes.
// Ports: clk, clear (sync reset), src_data/src_out/conflict_ack in;
//        bus_contents/bus_valid/bus_sel/conflict/conflict_sticky/conflict_count out.
module bus_mux_encoded #(
  parameter int              WIDTH        = 32,
  parameter int              NUM_SRC      = 32,
  parameter bit              HOLD_ON_IDLE = 1'b1,
  parameter logic [WIDTH-1:0] IDLE_VAL    = '0,
  localparam int             SEL_W        = $clog2(NUM_SRC)
) (
  input  logic                     clk,
  input  logic                     clear,
  input  logic [NUM_SRC*WIDTH-1:0] src_data,
  input  logic [NUM_SRC-1:0]       src_out,
  input  logic                     conflict_ack,
  output logic [WIDTH-1:0]         bus_contents,
  output logic                     bus_valid,
  output logic [SEL_W-1:0]         bus_sel,
  output logic                     conflict,
  output logic                     conflict_sticky,
  output logic [7:0]               conflict_count
);

  logic [WIDTH-1:0] bus_d, bus_q;
  logic             valid_d, valid_q;
  logic [SEL_W-1:0] sel_d, sel_q;
  logic             conf_d, conf_q;
  logic             sticky_d, sticky_q;
  logic [7:0]       count_d, count_q;

  logic [SEL_W-1:0] win;
  logic [WIDTH-1:0] win_data;
  logic             any;
  logic             multi;

  // Scan high to low so the lowest set strobe is the last to write.
  always_comb begin
    win      = '0;
    win_data = '0;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (src_out[i]) begin
        win      = SEL_W'(i);
        win_data = src_data[i*WIDTH +: WIDTH];
      end
    end
  end

  // x & (x-1) clears the lowest set bit; anything left means >= 2 strobes.
  always_comb begin
    any   = |src_out;
    multi = |(src_out & (src_out - NUM_SRC'(1)));
  end

  always_comb begin
    bus_d    = bus_q;
    valid_d  = 1'b0;
    sel_d    = sel_q;
    conf_d   = multi;
    sticky_d = sticky_q;
    count_d  = count_q;
    if (any) begin
      bus_d   = win_data;
      sel_d   = win;
      valid_d = 1'b1;
    end else if (!HOLD_ON_IDLE) begin
      bus_d = IDLE_VAL;
    end
    // Set beats ack when both land on the same cycle.
    if (multi) begin
      sticky_d = 1'b1;
    end else if (conflict_ack) begin
      sticky_d = 1'b0;
    end
    if (multi && count_q != 8'hFF) begin
      count_d = count_q + 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (clear) begin
      bus_q    <= IDLE_VAL;
      valid_q  <= 1'b0;
      sel_q    <= '0;
      conf_q   <= 1'b0;
      sticky_q <= 1'b0;
      count_q  <= 8'd0;
    end else begin
      bus_q    <= bus_d;
      valid_q  <= valid_d;
      sel_q    <= sel_d;
      conf_q   <= conf_d;
      sticky_q <= sticky_d;
      count_q  <= count_d;
    end
  end

  assign bus_contents    = bus_q;
  assign bus_valid       = valid_q;
  assign bus_sel         = sel_q;
  assign conflict        = conf_q;
  assign conflict_sticky = sticky_q;
  assign conflict_count  = count_q;

endmodule

// File: tb/tb_bus_mux_encoded.sv
// Scoreboard bench for bus_mux_encoded: default, zero-on-idle
// and narrow (16-bit, 8-source) instances.
module tb_bus_mux_encoded;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] bus;
    logic        valid;
    logic [5:0]  sel;
    logic        conf;
    logic        sticky;
    logic [7:0]  cnt;
  } exp_t;

  int tests = 0;
  int fails = 0;

  // main instance
  logic          clear = 1'b1;
  logic [1023:0] src_data = '0;
  logic [31:0]   src_out = '0;
  logic          conflict_ack = 1'b0;
  logic [31:0]   bus_contents;
  logic          bus_valid;
  logic [4:0]    bus_sel;
  logic          conflict;
  logic          conflict_sticky;
  logic [7:0]    conflict_count;

  bus_mux_encoded u_main (
    .clk(clk), .clear(clear), .src_data(src_data),
    .src_out(src_out), .conflict_ack(conflict_ack),
    .bus_contents(bus_contents), .bus_valid(bus_valid),
    .bus_sel(bus_sel), .conflict(conflict),
    .conflict_sticky(conflict_sticky),
    .conflict_count(conflict_count)
  );

  // zero-on-idle instance
  logic          i_clear = 1'b1;
  logic [1023:0] i_data = '0;
  logic [31:0]   i_out = '0;
  logic [31:0]   i_bus;
  logic          i_valid;
  logic [4:0]    i_sel;
  logic          i_conf, i_sticky;
  logic [7:0]    i_cnt;

  bus_mux_encoded #(
    .HOLD_ON_IDLE(1'b0), .IDLE_VAL(32'hFFFF_FFFF)
  ) u_idle (
    .clk(clk), .clear(i_clear), .src_data(i_data),
    .src_out(i_out), .conflict_ack(1'b0),
    .bus_contents(i_bus), .bus_valid(i_valid),
    .bus_sel(i_sel), .conflict(i_conf),
    .conflict_sticky(i_sticky), .conflict_count(i_cnt)
  );

  // narrow instance
  logic         s_clear = 1'b1;
  logic [127:0] s_data = '0;
  logic [7:0]   s_out = '0;
  logic [15:0]  s_bus;
  logic         s_valid;
  logic [2:0]   s_sel;
  logic         s_conf, s_sticky;
  logic [7:0]   s_cnt;

  bus_mux_encoded #(
    .WIDTH(16), .NUM_SRC(8)
  ) u_small (
    .clk(clk), .clear(s_clear), .src_data(s_data),
    .src_out(s_out), .conflict_ack(1'b0),
    .bus_contents(s_bus), .bus_valid(s_valid),
    .bus_sel(s_sel), .conflict(s_conf),
    .conflict_sticky(s_sticky), .conflict_count(s_cnt)
  );

  exp_t main_q[$];
  exp_t idle_q[$];
  exp_t small_q[$];

  // reference model state for the main instance
  logic [31:0] m_bus = '0;
  logic [5:0]  m_sel = '0;
  logic        m_sticky = 1'b0;
  logic [7:0]  m_cnt = '0;

  task automatic check(input string tag,
                       input logic [63:0] obs,
                       input logic [63:0] exp);
    tests++;
    if (obs !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic void set_src(int i, logic [31:0] v);
    src_data[i*32 +: 32] = v;
  endfunction

  task automatic step(input logic clr,
                      input logic [31:0] out,
                      input logic ack);
    exp_t e, g;
    int   n;
    bit   found;
    @(negedge clk);
    clear        = clr;
    src_out      = out;
    conflict_ack = ack;
    if (clr) begin
      m_bus = '0; m_sel = '0; m_sticky = 1'b0; m_cnt = '0;
      e.valid = 1'b0; e.conf = 1'b0;
    end else begin
      n     = $countones(out);
      found = 1'b0;
      for (int i = 0; i < 32; i++) begin
        if (!found && out[i]) begin
          found = 1'b1;
          m_sel = 6'(i);
          m_bus = src_data[i*32 +: 32];
        end
      end
      e.valid = found;
      e.conf  = (n >= 2);
      if (n >= 2) begin
        m_sticky = 1'b1;
        if (m_cnt != 8'd255) m_cnt = m_cnt + 8'd1;
      end else if (ack) begin
        m_sticky = 1'b0;
      end
    end
    e.bus = m_bus; e.sel = m_sel;
    e.sticky = m_sticky; e.cnt = m_cnt;
    main_q.push_back(e);
    @(posedge clk);
    #1;
    if (main_q.size() == 0) begin
      check("main_q_empty", 64'd1, 64'd0);
    end else begin
      g = main_q.pop_front();
      check("bus", 64'(bus_contents), 64'(g.bus));
      check("valid", 64'(bus_valid), 64'(g.valid));
      check("sel", 64'(bus_sel), 64'(g.sel));
      check("conflict", 64'(conflict), 64'(g.conf));
      check("sticky", 64'(conflict_sticky), 64'(g.sticky));
      check("count", 64'(conflict_count), 64'(g.cnt));
    end
  endtask

  task automatic step_i(input logic clr, input logic [31:0] out,
                        input logic [31:0] eb, input logic ev);
    exp_t e, g;
    @(negedge clk);
    i_clear = clr;
    i_out   = out;
    e = '{bus: eb, valid: ev, sel: '0, conf: 1'b0,
          sticky: 1'b0, cnt: '0};
    idle_q.push_back(e);
    @(posedge clk);
    #1;
    g = idle_q.pop_front();
    check("idle_bus", 64'(i_bus), 64'(g.bus));
    check("idle_valid", 64'(i_valid), 64'(g.valid));
  endtask

  task automatic step_s(input logic clr, input logic [7:0] out,
                        input logic [15:0] eb, input logic [2:0] es,
                        input logic ev, input logic ec);
    exp_t e, g;
    @(negedge clk);
    s_clear = clr;
    s_out   = out;
    e = '{bus: 32'(eb), valid: ev, sel: 6'(es), conf: ec,
          sticky: 1'b0, cnt: '0};
    small_q.push_back(e);
    @(posedge clk);
    #1;
    g = small_q.pop_front();
    check("small_bus", 64'(s_bus), 64'(g.bus));
    check("small_sel", 64'(s_sel), 64'(g.sel));
    check("small_valid", 64'(s_valid), 64'(g.valid));
    check("small_conf", 64'(s_conf), 64'(g.conf));
  endtask

  initial begin
    for (int i = 0; i < 32; i++) set_src(i, 32'hA500_0000 + 32'(i * 32'h111));
    set_src(5, 32'hDEAD_BEEF);

    // reset with a strobe present
    step(1'b1, 32'h1 << 3, 1'b0);
    step(1'b1, 32'h1 << 3, 1'b0);
    step(1'b0, 32'h1 << 3, 1'b0);

    // single drive then idle hold
    step(1'b0, 32'h20, 1'b0);
    step(1'b0, 32'h0, 1'b0);

    // conflict, ack, ack colliding with new conflict
    step(1'b0, 32'h0000_0410, 1'b0);
    step(1'b0, 32'h0, 1'b0);
    step(1'b0, 32'h0, 1'b1);
    step(1'b0, 32'h0000_0410, 1'b1);
    step(1'b0, 32'h0, 1'b0);

    // back-to-back 0, 1, 31
    set_src(0, 32'h1111_0000);
    set_src(1, 32'h2222_0001);
    set_src(31, 32'h3333_001F);
    step(1'b0, 32'h1, 1'b0);
    step(1'b0, 32'h2, 1'b0);
    step(1'b0, 32'h8000_0000, 1'b0);

    // held strobe with changing data
    for (int k = 0; k < 4; k++) begin
      set_src(7, 32'hC0DE_0000 + 32'(k));
      step(1'b0, 32'h80, 1'b0);
    end

    // clear mid-transfer discards the load
    step(1'b1, 32'h10, 1'b0);
    step(1'b0, 32'h0, 1'b0);

    // saturation
    for (int k = 0; k < 300; k++) begin
      set_src(0, 32'(k));
      step(1'b0, 32'h3, 1'b0);
    end
    step(1'b0, 32'h0, 1'b1);
    step(1'b0, 32'h4, 1'b0);

    // zero-on-idle instance
    i_data[2*32 +: 32] = 32'h12;
    i_data[9*32 +: 32] = 32'h99;
    step_i(1'b1, 32'h0, 32'hFFFF_FFFF, 1'b0);
    step_i(1'b0, 32'h4, 32'h12, 1'b1);
    step_i(1'b0, 32'h0, 32'hFFFF_FFFF, 1'b0);
    step_i(1'b0, 32'h200, 32'h99, 1'b1);
    step_i(1'b0, 32'h0, 32'hFFFF_FFFF, 1'b0);

    // narrow instance
    for (int i = 0; i < 8; i++) s_data[i*16 +: 16] = 16'hB000 + 16'(i);
    step_s(1'b1, 8'h0, 16'h0, 3'd0, 1'b0, 1'b0);
    step_s(1'b0, 8'h80, 16'hB007, 3'd7, 1'b1, 1'b0);
    step_s(1'b0, 8'h24, 16'hB002, 3'd2, 1'b1, 1'b1);
    step_s(1'b0, 8'h0, 16'hB002, 3'd2, 1'b0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/bus_mux_encoded.md
Name: bus_mux_encoded

Overview:
Parametrised registered bus multiplexer for the datapath's shared bus. It replaces binary-select sourcing with one-hot "out" strobes from the control unit, which are priority-encoded internally. The selected source is registered onto the bus with one-cycle latency. Multi-driver conflicts are detected, flagged and counted for debug and verification. The block sits between all bus sources (registers, PC, IR, MDR, ALU result, immediate) and the bus consumers.

Parameters:
WIDTH, 32, bit width of each source and of the bus
NUM_SRC, 32, number of bus sources (legal range 2..64)
HOLD_ON_IDLE, 1, 1 = bus holds its last value when no strobe is active; 0 = bus loads IDLE_VAL
IDLE_VAL, 0, bus value on reset, and on idle cycles when HOLD_ON_IDLE=0
Derived localparam: SEL_W = clog2(NUM_SRC)

Ports:
clk  input  1  rising-edge clock
clear  input  1  synchronous active-high reset
src_data  input  NUM_SRC*WIDTH  flattened sources; source i occupies bits [i*WIDTH +: WIDTH]
src_out  input  NUM_SRC  one-hot drive strobes; bit i requests source i onto the bus
conflict_ack  input  1  clears conflict_sticky
bus_contents  output  WIDTH  registered bus value
bus_valid  output  1  registered; 1 when bus_contents was loaded from a source on the previous edge
bus_sel  output  SEL_W  registered index of the source last driven
conflict  output  1  registered one-cycle pulse; more than one strobe was active on the previous edge
conflict_sticky  output  1  set on any conflict, held until conflict_ack or clear
conflict_count  output  8  saturating count of conflict cycles

Behaviour:
- All outputs are registered and update only on the rising edge of clk. Latency from src_out/src_data to bus_contents is exactly 1 cycle.
- clear (synchronous, highest priority): bus_contents=IDLE_VAL, bus_valid=0, bus_sel=0, conflict=0, conflict_sticky=0, conflict_count=0. While clear is high, src_out and conflict_ack are ignored.
- Encoding: the lowest-index set bit of src_out wins (fixed priority, index 0 highest).
- At least one strobe set: bus_contents<=src_data[win], bus_sel<=win, bus_valid<=1.
- No strobe set: bus_valid<=0 and bus_sel holds. bus_contents holds if HOLD_ON_IDLE=1; otherwise it loads IDLE_VAL.
- Conflict (popcount(src_out)>=2):
  - conflict<=1 for that cycle only, otherwise 0.
  - conflict_sticky<=1.
  - conflict_count increments and saturates at 255 (no wrap).
  - The bus is still driven by the priority winner, and bus_valid=1.
- conflict_ack: conflict_sticky<=0, unless a conflict occurs in the same cycle, in which case set wins and sticky stays 1. conflict_ack does not affect conflict_count; only clear zeroes it.
- Back-to-back strobes for different sources in consecutive cycles give consecutive bus values with no bubble. Full throughput, no stall.
- Clear asserted mid-transfer: the pending load is discarded, and the bus shows IDLE_VAL on the next edge.
- src_data changes while the strobe is held: the bus tracks the new value with 1-cycle delay, each cycle.
- No X propagation: unused or undriven sources never reach the bus unless strobed.

Test Plan:
- Reset: drive clear=1 for 2 cycles with src_out=1<<3 -> bus_contents=0, bus_valid=0, conflict_count=0. After clear drops, bus=src 3 value one cycle later.
- Single drive: src 5=32'hDEADBEEF, src_out=32'h20 for 1 cycle -> next edge bus_contents=DEADBEEF, bus_sel=5, bus_valid=1. Following idle cycle (HOLD_ON_IDLE=1) -> bus stays DEADBEEF, bus_valid=0.
- Idle mode: HOLD_ON_IDLE=0, IDLE_VAL=32'hFFFFFFFF, pulse src 2=0x12 then idle -> bus 0x12, then FFFFFFFF.
- Conflict: src_out=32'h0000_0410 (sources 4 and 10) -> bus=src 4, conflict pulse 1 cycle, sticky=1, count=1. Assert conflict_ack on a later clean cycle -> sticky=0, count stays 1. Ack coincident with a new conflict -> sticky stays 1, count=2.
- Saturation: 300 consecutive conflict cycles -> conflict_count=255 and holds.
- Back-to-back: strobes 0,1,31 on consecutive cycles with distinct data -> the three values appear on consecutive edges. Also rerun with WIDTH=16, NUM_SRC=8 and check that bus_sel is 3 bits wide.
